// File: rtl/id_issue_scoreboard_pkg.sv
// Shared widths, ID-stage state encoding and decoded-payload field layout
// for the ID/EX issue scoreboard.
package id_issue_scoreboard_pkg;

  localparam int XLEN_DEF       = 64;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int CNT_W_DEF      = 2;
  localparam int PAYLOAD_W_DEF  = 128;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    CTRL_WAIT = 2'd1,
    HALT      = 2'd2
  } issue_state_t;

  // Layout of the opaque payload; the scoreboard never looks inside it.
  localparam int PL_IMM_LSB     = 0;
  localparam int PL_IMM_W       = 64;
  localparam int PL_ALU_OP_LSB  = PL_IMM_LSB + PL_IMM_W;
  localparam int PL_ALU_OP_W    = 6;
  localparam int PL_SRC_SEL_LSB = PL_ALU_OP_LSB + PL_ALU_OP_W;
  localparam int PL_SRC_SEL_W   = 4;
  localparam int PL_MASK_LSB    = PL_SRC_SEL_LSB + PL_SRC_SEL_W;
  localparam int PL_MASK_W      = 8;

endpackage

// File: rtl/id_pend_table.sv
// Per-register pending-write counters with one increment port, two decrement
// ports, two busy lookups and a saturation lookup. Register 0 is never counted.
module id_pend_table #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_en,
  input  logic [REG_ADDR_W-1:0] inc_addr,
  input  logic                  dec_a_en,
  input  logic [REG_ADDR_W-1:0] dec_a_addr,
  input  logic                  dec_b_en,
  input  logic [REG_ADDR_W-1:0] dec_b_addr,
  input  logic [REG_ADDR_W-1:0] look_a_addr,
  input  logic [REG_ADDR_W-1:0] look_b_addr,
  input  logic [REG_ADDR_W-1:0] sat_addr,
  output logic                  look_a_busy,
  output logic                  look_b_busy,
  output logic                  sat_full
);

  localparam int NREG = 2**REG_ADDR_W;

  logic [NREG-1:0][CNT_W-1:0] cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign cnt[gi] = '0;
      end else begin : g_live
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;
        logic [CNT_W:0]   sum;
        logic [1:0]       dec;

        // Two decrements can land together (retire + flush of the slot);
        // anything that would go below zero is clamped.
        always_comb begin
          sum = {1'b0, cnt_reg}
              + {{CNT_W{1'b0}}, (inc_en && inc_addr == REG_ADDR_W'(gi))};
          dec = {1'b0, (dec_a_en && dec_a_addr == REG_ADDR_W'(gi))}
              + {1'b0, (dec_b_en && dec_b_addr == REG_ADDR_W'(gi))};
          cnt_next = '0;
          if (sum >= (CNT_W+1)'(dec)) begin
            cnt_next = CNT_W'(sum - (CNT_W+1)'(dec));
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_next;
          end
        end

        assign cnt[gi] = cnt_reg;
      end
    end
  endgenerate

  assign look_a_busy = (cnt[look_a_addr] != '0);
  assign look_b_busy = (cnt[look_b_addr] != '0);
  assign sat_full    = &cnt[sat_addr];

endmodule

// File: rtl/id_issue_scoreboard.sv
// ID/EX issue slot: RAW/saturation hazard stalls from a pending-write table,
// control-flow wait, ebreak halt and valid/ready handshakes on both sides.
module id_issue_scoreboard
  import id_issue_scoreboard_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PAYLOAD_W  = PAYLOAD_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  in_rs1_used,
  input  logic                  in_rs2_used,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_wen,
  input  logic                  in_is_ctrl,
  input  logic                  in_is_ebreak,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_waddr,
  input  logic                  ctrl_resolve,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_wen,
  output logic [PAYLOAD_W-1:0]  out_payload,
  output logic                  stall_raw,
  output logic                  halted
);

  issue_state_t state_reg, state_next;

  logic rs1_busy, rs2_busy, rd_full;
  logic hazard, sat, issue;

  id_pend_table #(
    .REG_ADDR_W (REG_ADDR_W),
    .CNT_W      (CNT_W)
  ) u_pend (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_en      (issue & in_reg_wen & (in_rd != '0)),
    .inc_addr    (in_rd),
    .dec_a_en    (wb_valid),
    .dec_a_addr  (wb_waddr),
    .dec_b_en    (flush & out_valid & out_reg_wen),
    .dec_b_addr  (out_rd),
    .look_a_addr (in_rs1),
    .look_b_addr (in_rs2),
    .sat_addr    (in_rd),
    .look_a_busy (rs1_busy),
    .look_b_busy (rs2_busy),
    .sat_full    (rd_full)
  );

  assign hazard = (in_rs1_used & (in_rs1 != '0) & rs1_busy)
                | (in_rs2_used & (in_rs2 != '0) & rs2_busy);
  assign sat    = in_reg_wen & (in_rd != '0) & rd_full;

  assign stall_raw = in_valid & (hazard | sat);
  assign in_ready  = (state_reg == RUN) & ~hazard & ~sat
                   & (~out_valid | out_ready) & ~flush;
  assign issue     = in_valid & in_ready;
  assign halted    = (state_reg == HALT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (issue & in_is_ebreak) begin
          state_next = HALT;
        end else if (issue & in_is_ctrl) begin
          state_next = CTRL_WAIT;
        end
      end
      CTRL_WAIT: begin
        if (ctrl_resolve) begin
          state_next = RUN;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Flush wins over everything; in_ready is already low in a flush cycle,
  // so it can never coincide with a fresh issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_rd      <= '0;
      out_reg_wen <= 1'b0;
      out_payload <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_rd      <= in_rd;
      out_reg_wen <= in_reg_wen;
      out_payload <= in_payload;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_issue_scoreboard.sv
// Randomised bench for id_issue_scoreboard against a transaction-level model
// (pending counts per register, list of writes in flight in EX, one slot).
module tb_id_issue_scoreboard;

  localparam int XLEN = 64;
  localparam int RA   = 5;
  localparam int CW   = 2;
  localparam int PW   = 128;
  localparam int NREG = 32;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [XLEN-1:0] in_pc;
  logic [RA-1:0] in_rs1, in_rs2, in_rd;
  logic          in_rs1_used, in_rs2_used, in_reg_wen, in_is_ctrl, in_is_ebreak;
  logic [PW-1:0] in_payload;
  logic          wb_valid;
  logic [RA-1:0] wb_waddr;
  logic          ctrl_resolve, flush;
  logic          out_valid, out_ready;
  logic [XLEN-1:0] out_pc;
  logic [RA-1:0] out_rd;
  logic          out_reg_wen;
  logic [PW-1:0] out_payload;
  logic          stall_raw, halted;

  always #5 clk = ~clk;

  id_issue_scoreboard #(.XLEN(XLEN), .REG_ADDR_W(RA), .CNT_W(CW), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_rd(in_rd), .in_reg_wen(in_reg_wen), .in_is_ctrl(in_is_ctrl),
    .in_is_ebreak(in_is_ebreak), .in_payload(in_payload),
    .wb_valid(wb_valid), .wb_waddr(wb_waddr),
    .ctrl_resolve(ctrl_resolve), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_reg_wen(out_reg_wen), .out_payload(out_payload),
    .stall_raw(stall_raw), .halted(halted)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[%0t] FAIL %s: got %0h, expected %0h", $time, tag, got, exp);
    end
  endtask

  // Model: 0 = running, 1 = waiting for control resolve, 2 = halted.
  int            pend[NREG];
  int            inflight[$];
  int            mode;
  logic          slot_v, slot_wen;
  logic [XLEN-1:0] slot_pc;
  logic [RA-1:0] slot_rd;
  logic [PW-1:0] slot_pl;
  int            wb_idx;
  logic          exp_ready;

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) pend[r] = 0;
    inflight.delete();
    mode     = 0;
    slot_v   = 1'b0;
    slot_wen = 1'b0;
    slot_pc  = '0;
    slot_rd  = '0;
    slot_pl  = '0;
  endtask

  task automatic drive_idle();
    in_valid = 0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_rs1_used = 0; in_rs2_used = 0; in_reg_wen = 0; in_is_ctrl = 0;
    in_is_ebreak = 0; in_payload = '0; wb_valid = 0; wb_waddr = '0;
    ctrl_resolve = 0; flush = 0; out_ready = 0;
  endtask

  task automatic drive_random(input int ebreak_pm);
    in_valid     = ($urandom % 10) < 7;
    in_pc        = {$urandom, $urandom};
    in_payload   = {$urandom, $urandom, $urandom, $urandom};
    in_rs1       = RA'($urandom % 8);
    in_rs2       = RA'($urandom % 8);
    in_rd        = RA'($urandom % 8);
    in_rs1_used  = $urandom % 2;
    in_rs2_used  = $urandom % 2;
    in_reg_wen   = ($urandom % 10) < 7;
    in_is_ctrl   = ($urandom % 100) < 6;
    in_is_ebreak = !in_is_ctrl && (($urandom % 1000) < ebreak_pm);
    out_ready    = ($urandom % 10) < 7;
    wb_idx       = -1;
    wb_valid     = 0;
    wb_waddr     = RA'($urandom % NREG);
    if (inflight.size() > 0 && ($urandom % 10) < 4) begin
      wb_idx   = int'($urandom % inflight.size());
      wb_valid = 1;
      wb_waddr = RA'(inflight[wb_idx]);
    end
    ctrl_resolve = (mode == 1) && (($urandom % 4) == 0);
    flush        = ctrl_resolve && ($urandom % 2);
  endtask

  task automatic check_comb();
    bit hz, st;
    hz = (in_rs1_used && in_rs1 != 0 && pend[in_rs1] != 0) ||
         (in_rs2_used && in_rs2 != 0 && pend[in_rs2] != 0);
    st = in_reg_wen && in_rd != 0 && pend[in_rd] == CMAX;
    exp_ready = (mode == 0) && !hz && !st && (!slot_v || out_ready) && !flush;
    check_eq("in_ready",    in_ready,    exp_ready);
    check_eq("stall_raw",   stall_raw,   in_valid && (hz || st));
    check_eq("out_valid",   out_valid,   slot_v);
    check_eq("out_pc",      out_pc,      slot_pc);
    check_eq("out_rd",      out_rd,      slot_rd);
    check_eq("out_reg_wen", out_reg_wen, slot_wen);
    check_eq("out_payload", out_payload, slot_pl);
    check_eq("halted",      halted,      mode == 2);
  endtask

  task automatic model_step();
    bit issue, accepted;
    issue    = in_valid && exp_ready;
    accepted = slot_v && out_ready && !flush;
    if (accepted && slot_wen && slot_rd != 0) inflight.push_back(int'(slot_rd));
    if (flush && slot_v && slot_wen && slot_rd != 0) pend[slot_rd]--;
    if (wb_idx >= 0) begin
      pend[wb_waddr]--;
      inflight.delete(wb_idx);
    end
    if (issue && in_reg_wen && in_rd != 0) pend[in_rd]++;
    if (flush) slot_v = 0;
    else if (issue) begin
      slot_v = 1; slot_pc = in_pc; slot_rd = in_rd; slot_wen = in_reg_wen; slot_pl = in_payload;
    end else if (accepted) slot_v = 0;
    if (mode == 0 && issue) begin
      if (in_is_ebreak) mode = 2;
      else if (in_is_ctrl) mode = 1;
    end else if (mode == 1 && ctrl_resolve) mode = 0;
    if (issue)
      $display("[%0t] issue pc=%h rd=%0d wen=%0d ctrl=%0d ebreak=%0d",
               $time, in_pc, in_rd, in_reg_wen, in_is_ctrl, in_is_ebreak);
  endtask

  task automatic run_cycle(input int ebreak_pm);
    @(negedge clk);
    drive_random(ebreak_pm);
    #1;
    check_comb();
    @(posedge clk);
    model_step();
  endtask

  task automatic check_reset_state();
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_halted",    halted,    1'b0);
    check_eq("rst_out_pc",    out_pc,    '0);
    check_eq("rst_payload",   out_payload, '0);
    check_eq("rst_in_ready",  in_ready,  1'b1);
  endtask

  initial begin
    rst_n = 0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_state();
    rst_n = 1;
    for (int ep = 0; ep < 6; ep++) begin
      for (int c = 0; c < 300; c++) run_cycle(0);
      for (int c = 0; c < 150; c++) run_cycle(30);
      // Asynchronous reset asserted between clock edges.
      @(negedge clk);
      drive_idle();
      #2;
      rst_n = 0;
      #1;
      check_reset_state();
      $display("[%0t] reset epoch=%0d halted_before=%0d", $time, ep, mode == 2);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
